// File: rtl/mesh_router_param.sv
// mesh_router_param: one wormhole mesh router for every mesh position.
//   The router has five ports: N, S, W, E and L (local). PORT_EN removes the
//   ports that do not exist at edge and corner positions.
//   Each input has its own FIFO. Packets use YX routing. Each output has a
//   round-robin arbiter with a wormhole lock and a credit counter. A packet
//   that routes to a missing port, or back out of the port it came in on,
//   is consumed and counted as dropped.
//
// Ports (port index p: 0=N 1=S 2=W 3=E 4=L; vectors are packed by p)
//   clk              clock
//   reset            asynchronous active-low reset
//   yx_addr_router_i this router's {y,x}, static after reset
//   data_i/valid_i   incoming flits, one DATA_W lane per port
//   credit_i         one-cycle credit returned by each downstream buffer
//   data_o/valid_o   outgoing flits (registered)
//   credit_o         one-cycle credit sent upstream on each input FIFO pop
//   overflow_o       sticky: a flit arrived while that input FIFO was full
//   drop_cnt_o       saturating count of dropped (misrouted) packets
module mesh_router_param #(
  parameter int         DATA_W    = 16,
  parameter int         COORD_W   = 4,
  parameter int         BUF_DEPTH = 8,
  parameter logic [4:0] PORT_EN   = 5'b11111
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2*COORD_W-1:0] yx_addr_router_i,
  input  logic [5*DATA_W-1:0]  data_i,
  input  logic [4:0]           valid_i,
  input  logic [4:0]           credit_i,
  output logic [5*DATA_W-1:0]  data_o,
  output logic [4:0]           valid_o,
  output logic [4:0]           credit_o,
  output logic [4:0]           overflow_o,
  output logic [7:0]           drop_cnt_o
);

  localparam int NP    = 5;
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {IN_HEAD, IN_BODY, IN_DROP} in_state_t;

  // Tail and single flits both have the type MSB set.
  function automatic logic flit_is_tail(input logic [DATA_W-1:0] f);
    return f[DATA_W-1];
  endfunction

  // YX routing: y grows southward, x grows eastward.
  function automatic logic [2:0] yx_route(input logic [2*COORD_W-1:0] dest,
                                          input logic [2*COORD_W-1:0] me);
    logic [COORD_W-1:0] dy, dx, my, mx;
    dy = dest[2*COORD_W-1:COORD_W];
    dx = dest[COORD_W-1:0];
    my = me[2*COORD_W-1:COORD_W];
    mx = me[COORD_W-1:0];
    if (dy < my)      return 3'd0;
    else if (dy > my) return 3'd1;
    else if (dx < mx) return 3'd2;
    else if (dx > mx) return 3'd3;
    return 3'd4;
  endfunction

  // Round-robin pick that starts at ptr. The result is {found, index}.
  function automatic logic [3:0] rr_pick(input logic [NP-1:0] r, input logic [2:0] ptr);
    logic [3:0] res;
    int         idx;
    res = 4'b0;
    for (int k = 0; k < NP; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NP) idx = idx - NP;
      if (!res[3] && r[idx]) res = {1'b1, 3'(idx)};
    end
    return res;
  endfunction

  // ---------------- input side ----------------
  logic [DATA_W-1:0] fifo_mem  [NP][BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr    [NP];
  logic [PTR_W-1:0]  rd_ptr    [NP];
  logic [PTR_W:0]    fill      [NP];
  logic [DATA_W-1:0] head_flit [NP];
  logic [2:0]        target    [NP];
  in_state_t         in_state     [NP];
  in_state_t         in_state_nxt [NP];
  logic [NP-1:0]     fifo_empty, fifo_full, fifo_wr, pop;
  logic [NP-1:0]     misroute, head_req, drop_start, drop_pop;
  logic [NP-1:0]     credit_q, overflow_q;
  logic [7:0]        drop_cnt_q;
  logic [2:0]        drop_inc;
  logic [8:0]        drop_sum;

  // ---------------- output side ----------------
  logic [NP-1:0]             req [NP];
  logic [NP-1:0]             gnt_found;
  logic [2:0]                gnt_idx  [NP];
  logic [NP-1:0]             out_locked;
  logic [2:0]                owner    [NP];
  logic [2:0]                rr_ptr   [NP];
  logic [NP-1:0][CNT_W-1:0]  credit_cnt;
  logic [NP-1:0]             send, credit_in;
  logic [2:0]                send_src [NP];
  logic [DATA_W-1:0]         data_q   [NP];
  logic [NP-1:0]             valid_q;

  // NOTE: every signal driven in always_comb gets a value on all paths
  // (defaults first), so no latches are inferred.
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      head_flit[p]  = fifo_mem[p][rd_ptr[p]];
      fifo_empty[p] = (fill[p] == '0);
      fifo_full[p]  = (fill[p] == (PTR_W+1)'(BUF_DEPTH));
      target[p]     = yx_route(head_flit[p][2*COORD_W-1:0], yx_addr_router_i);
      // Misroute: the target port is missing, or the packet would U-turn.
      misroute[p]   = !PORT_EN[target[p]] || (target[p] == 3'(p));
      head_req[p]   = PORT_EN[p] && (in_state[p] == IN_HEAD) && !fifo_empty[p] && !misroute[p];
      drop_start[p] = PORT_EN[p] && (in_state[p] == IN_HEAD) && !fifo_empty[p] && misroute[p];
      drop_pop[p]   = drop_start[p] ||
                      (PORT_EN[p] && (in_state[p] == IN_DROP) && !fifo_empty[p]);
    end
  end

  // Arbitration and send selection. An input requests only the output its
  // head routes to, so a FIFO head is served by at most one output.
  always_comb begin
    pop = drop_pop;
    for (int o = 0; o < NP; o++) begin
      for (int p = 0; p < NP; p++)
        req[o][p] = head_req[p] && (target[p] == 3'(o)) && PORT_EN[o] &&
                    !out_locked[o] && (credit_cnt[o] != '0);
      {gnt_found[o], gnt_idx[o]} = rr_pick(req[o], rr_ptr[o]);
      if (out_locked[o]) begin
        send_src[o] = owner[o];
        send[o]     = !fifo_empty[owner[o]] && (credit_cnt[o] != '0);
      end else begin
        send_src[o] = gnt_idx[o];
        send[o]     = gnt_found[o];
      end
    end
    for (int o = 0; o < NP; o++)
      if (send[o]) pop[send_src[o]] = 1'b1;
  end

  // Per-input packet state. A popped tail ends the packet. A popped
  // non-tail head starts either forwarding or dropping.
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      in_state_nxt[p] = in_state[p];
      if (pop[p]) begin
        if (flit_is_tail(head_flit[p]))
          in_state_nxt[p] = IN_HEAD;
        else if (in_state[p] == IN_HEAD)
          in_state_nxt[p] = drop_start[p] ? IN_DROP : IN_BODY;
      end
    end
  end

  // A full FIFO still accepts a flit in a cycle where it also pops.
  assign fifo_wr   = valid_i & PORT_EN & (~fifo_full | pop);
  assign credit_in = credit_i & PORT_EN;

  always_comb begin
    drop_inc = '0;
    for (int p = 0; p < NP; p++) drop_inc = drop_inc + 3'(drop_start[p]);
    drop_sum = {1'b0, drop_cnt_q} + 9'(drop_inc);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the values from before the clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < NP; p++) begin
        wr_ptr[p]   <= '0;
        rd_ptr[p]   <= '0;
        fill[p]     <= '0;
        in_state[p] <= IN_HEAD;
      end
      credit_q   <= '0;
      overflow_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (fifo_wr[p]) wr_ptr[p] <= wr_ptr[p] + 1'b1;
        if (pop[p])     rd_ptr[p] <= rd_ptr[p] + 1'b1;
        fill[p]     <= fill[p] + (PTR_W+1)'(fifo_wr[p]) - (PTR_W+1)'(pop[p]);
        in_state[p] <= in_state_nxt[p];
      end
      credit_q   <= pop & PORT_EN;
      overflow_q <= overflow_q | (valid_i & PORT_EN & fifo_full & ~pop);
      drop_cnt_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  // NOTE: the FIFO storage has no reset. The pointers and fill counts
  // define which entries are valid, so stale contents are never read.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NP; p++)
      if (fifo_wr[p]) fifo_mem[p][wr_ptr[p]] <= data_i[p*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_locked <= '0;
      valid_q    <= '0;
      credit_cnt <= {NP{CNT_W'(BUF_DEPTH)}};
      for (int o = 0; o < NP; o++) begin
        owner[o]  <= '0;
        rr_ptr[o] <= '0;
        data_q[o] <= '0;
      end
    end else begin
      for (int o = 0; o < NP; o++) begin
        valid_q[o] <= send[o];
        if (send[o]) data_q[o] <= head_flit[send_src[o]];

        // A grant moves the pointer past the winner. A multi-flit packet
        // also locks the output until its tail leaves.
        if (!out_locked[o] && gnt_found[o]) begin
          rr_ptr[o] <= (gnt_idx[o] == 3'(NP-1)) ? 3'd0 : gnt_idx[o] + 3'd1;
          if (!flit_is_tail(head_flit[gnt_idx[o]])) begin
            out_locked[o] <= 1'b1;
            owner[o]      <= gnt_idx[o];
          end
        end else if (out_locked[o] && send[o] && flit_is_tail(head_flit[owner[o]])) begin
          out_locked[o] <= 1'b0;
        end

        case ({send[o], credit_in[o]})
          2'b10:   credit_cnt[o] <= credit_cnt[o] - 1'b1;
          2'b01:   if (credit_cnt[o] != CNT_W'(BUF_DEPTH)) credit_cnt[o] <= credit_cnt[o] + 1'b1;
          default: ;
        endcase
      end
    end
  end

  // A credit that arrives while the counter is already full points to an
  // upstream accounting bug. The counter ignores it.
  for (genvar o = 0; o < NP; o++) begin : g_credit_chk
    credit_overflow_a : assert property (@(posedge clk) disable iff (!reset)
      !(credit_in[o] && !send[o] && (credit_cnt[o] == CNT_W'(BUF_DEPTH))));
  end

  for (genvar o = 0; o < NP; o++) begin : g_out
    assign data_o[o*DATA_W +: DATA_W] = PORT_EN[o] ? data_q[o] : '0;
  end
  assign valid_o    = valid_q & PORT_EN;
  assign credit_o   = credit_q;
  assign overflow_o = overflow_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_mesh_router_param.sv
// Directed testbench for mesh_router_param. The router sits at (2,2).
// dut has every port enabled. dut_dis has its E port disabled.
module tb_mesh_router_param;
  localparam int DW = 16;
  localparam int CW = 4;
  localparam int BD = 8;

  logic            clk, reset;
  logic [2*CW-1:0] yx_addr;
  logic [5*DW-1:0] data_i, data_o, data_i2, data_o2;
  logic [4:0]      valid_i, credit_i, valid_o, credit_o, overflow_o;
  logic [4:0]      valid_i2, credit_i2, valid_o2, credit_o2, overflow_o2;
  logic [7:0]      drop_cnt_o, drop_cnt_o2;
  int              n_cmp = 0;
  int              n_bad = 0;

  mesh_router_param #(.DATA_W(DW), .COORD_W(CW), .BUF_DEPTH(BD), .PORT_EN(5'b11111)) dut (
    .clk(clk), .reset(reset), .yx_addr_router_i(yx_addr),
    .data_i(data_i), .valid_i(valid_i), .credit_i(credit_i),
    .data_o(data_o), .valid_o(valid_o), .credit_o(credit_o),
    .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o));

  mesh_router_param #(.DATA_W(DW), .COORD_W(CW), .BUF_DEPTH(BD), .PORT_EN(5'b10111)) dut_dis (
    .clk(clk), .reset(reset), .yx_addr_router_i(yx_addr),
    .data_i(data_i2), .valid_i(valid_i2), .credit_i(credit_i2),
    .data_o(data_o2), .valid_o(valid_o2), .credit_o(credit_o2),
    .overflow_o(overflow_o2), .drop_cnt_o(drop_cnt_o2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] flit(input logic [1:0] t, input logic [5:0] pl,
                                         input logic [3:0] y, input logic [3:0] x);
    return {t, pl, y, x};
  endfunction
  function automatic logic [DW-1:0] body(input logic [13:0] pl);
    return {2'b00, pl};
  endfunction
  function automatic logic [DW-1:0] tail(input logic [13:0] pl);
    return {2'b10, pl};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    valid_i = '0; credit_i = '0; data_i = '0;
    valid_i2 = '0; credit_i2 = '0; data_i2 = '0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic check_counters_full(input string tag);
    for (int k = 0; k < 5; k++)
      check($sformatf("%s credit_cnt[%0d]", tag, k), dut.credit_cnt[k], BD);
  endtask

  // A single flit from L to (2,5) must leave on E two cycles later.
  task automatic test_local_to_e();
    logic [DW-1:0] f;
    f = flit(2'b11, 6'h2A, 4'd2, 4'd5);
    data_i[4*DW +: DW] = f;
    valid_i = 5'b10000;
    tick();
    valid_i = '0;
    check("t1 valid_o at t+1", valid_o, 5'b00000);
    tick();
    check("t1 valid_o at t+2", valid_o, 5'b01000);
    check("t1 data E", data_o[3*DW +: DW], f);
    check("t1 credit_o at t+2", credit_o, 5'b10000);
    tick();
    check("t1 valid_o after", valid_o, 5'b00000);
    check("t1 credit_o single pulse", credit_o, 5'b00000);
    check("t1 data E held", data_o[3*DW +: DW], f);
    check("t1 E credit counter", dut.credit_cnt[3], BD - 1);
  endtask

  // N and W each send a 4-flit packet to L. N wins first because it has
  // the higher starting priority, and the two packets must not interleave.
  task automatic test_wormhole();
    logic [DW-1:0] n_pkt [4];
    logic [DW-1:0] w_pkt [4];
    logic [DW-1:0] got_q [$];
    logic [DW-1:0] exp_f, got_f;
    int first_c, last_c;
    logic other_v;
    n_pkt = '{flit(2'b01, 6'h11, 4'd2, 4'd2), body(14'h101), body(14'h102), tail(14'h103)};
    w_pkt = '{flit(2'b01, 6'h22, 4'd2, 4'd2), body(14'h201), body(14'h202), tail(14'h203)};
    first_c = -1; last_c = -1; other_v = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (c < 4) begin
        data_i[0*DW +: DW] = n_pkt[c];
        data_i[2*DW +: DW] = w_pkt[c];
        valid_i = 5'b00101;
      end else begin
        valid_i = '0;
      end
      tick();
      if (valid_o[4]) begin
        got_q.push_back(data_o[4*DW +: DW]);
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      if (valid_o[3:0] != 4'b0) other_v = 1'b1;
    end
    check("t2 flit count on L", got_q.size(), 8);
    check("t2 contiguous span", last_c - first_c, 7);
    check("t2 no other outputs", other_v, 1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_f = (i < 4) ? n_pkt[i] : w_pkt[i-4];
      got_f = (i < got_q.size()) ? got_q[i] : 'x;
      check($sformatf("t2 L flit %0d", i), got_f, exp_f);
    end
  endtask

  // A 10-flit packet goes from N to S with no credits returned. Eight flits
  // leave, then each credit pulse releases exactly one more flit.
  task automatic test_credit_stall();
    int cnt;
    logic [DW-1:0] last_f;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 0)      data_i[0*DW +: DW] = flit(2'b01, 6'h30, 4'd4, 4'd2);
      else if (c < 9)  data_i[0*DW +: DW] = body(14'h200 + 14'(c));
      else if (c == 9) data_i[0*DW +: DW] = tail(14'h209);
      valid_i = (c < 10) ? 5'b00001 : 5'b00000;
      tick();
      if (valid_o[1]) cnt++;
    end
    check("t3 flits before credit", cnt, 8);
    check("t3 S credit counter", dut.credit_cnt[1], 0);
    for (int pulse = 0; pulse < 2; pulse++) begin
      credit_i = 5'b00010;
      tick();
      credit_i = '0;
      cnt = 0; last_f = '0;
      for (int c = 0; c < 4; c++) begin
        tick();
        if (valid_o[1]) begin cnt++; last_f = data_o[1*DW +: DW]; end
      end
      check($sformatf("t3 flits after pulse %0d", pulse), cnt, 1);
      check($sformatf("t3 data after pulse %0d", pulse), last_f,
            (pulse == 0) ? body(14'h208) : tail(14'h209));
    end
  endtask

  // The first packet uses all S credits. Then 12 flits go into N: the FIFO
  // holds 8, and flit 9 is the first one discarded.
  task automatic test_overflow();
    logic sent_v;
    for (int c = 0; c < 12; c++) begin
      if (c == 0)      data_i[0*DW +: DW] = flit(2'b01, 6'h01, 4'd4, 4'd2);
      else if (c < 7)  data_i[0*DW +: DW] = body(14'h300 + 14'(c));
      else if (c == 7) data_i[0*DW +: DW] = tail(14'h307);
      valid_i = (c < 8) ? 5'b00001 : 5'b00000;
      tick();
    end
    sent_v = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      data_i[0*DW +: DW] = (k == 1) ? flit(2'b01, 6'h02, 4'd4, 4'd2) : body(14'h400 + 14'(k));
      valid_i = 5'b00001;
      tick();
      if (k == 8) check("t4 overflow after flit 8", overflow_o, 5'b00000);
      if (k == 9) check("t4 overflow after flit 9", overflow_o, 5'b00001);
      if (valid_o[1]) sent_v = 1'b1;
    end
    valid_i = '0;
    tick();
    check("t4 overflow final", overflow_o, 5'b00001);
    check("t4 nothing sent without credit", sent_v, 1'b0);
  endtask

  // With E disabled, a packet to (2,5) is consumed and counted as one drop.
  // Traffic driven on the disabled E input is ignored.
  task automatic test_disabled_port();
    int l_credits;
    logic any_v, e_cred;
    l_credits = 0; any_v = 1'b0; e_cred = 1'b0;
    check("t5 drop count before", drop_cnt_o2, 0);
    for (int c = 0; c < 10; c++) begin
      if (c == 0)      data_i2[4*DW +: DW] = flit(2'b01, 6'h05, 4'd2, 4'd5);
      else if (c == 1) data_i2[4*DW +: DW] = body(14'h501);
      else if (c == 2) data_i2[4*DW +: DW] = tail(14'h502);
      data_i2[3*DW +: DW] = flit(2'b11, 6'h06, 4'd2, 4'd0);
      valid_i2 = (c < 3) ? 5'b11000 : 5'b00000;
      tick();
      if (credit_o2[4]) l_credits++;
      if (credit_o2[3]) e_cred = 1'b1;
      if (valid_o2 != 5'b0) any_v = 1'b1;
    end
    check("t5 L credits returned", l_credits, 3);
    check("t5 no output valid", any_v, 1'b0);
    check("t5 disabled input credit", e_cred, 1'b0);
    check("t5 drop count after", drop_cnt_o2, 1);
    check("t5 overflow flags", overflow_o2, 5'b00000);
    data_i2[4*DW +: DW] = flit(2'b11, 6'h07, 4'd2, 4'd0);
    valid_i2 = 5'b10000;
    tick();
    valid_i2 = '0;
    tick();
    check("t5 W after drop valid", valid_o2, 5'b00100);
    check("t5 W after drop data", data_o2[2*DW +: DW], flit(2'b11, 6'h07, 4'd2, 4'd0));
  endtask

  // Reset is asserted while a packet is in flight. The outputs must clear
  // at once, and after release a new packet must route normally.
  task automatic test_reset_mid_packet();
    logic stray_s;
    logic [DW-1:0] f;
    int e_cnt;
    data_i[0*DW +: DW] = flit(2'b01, 6'h08, 4'd4, 4'd2);
    valid_i = 5'b00001;
    tick();
    data_i[0*DW +: DW] = body(14'h601);
    tick();
    check("t6 head forwarded", valid_o, 5'b00010);
    check("t6 head credit", credit_o, 5'b00001);
    data_i[0*DW +: DW] = body(14'h602);
    #2;
    reset = 1'b0;
    #1;
    check("t6 async valid_o", valid_o, 5'b00000);
    check("t6 async credit_o", credit_o, 5'b00000);
    check("t6 async data_o", data_o, '0);
    check("t6 async drop_cnt", drop_cnt_o, 0);
    valid_i = '0;
    tick();
    tick();
    reset = 1'b1;
    check_counters_full("t6");
    f = flit(2'b11, 6'h09, 4'd2, 4'd5);
    data_i[4*DW +: DW] = f;
    valid_i = 5'b10000;
    stray_s = 1'b0; e_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      valid_i = '0;
      if (valid_o[1]) stray_s = 1'b1;
      if (valid_o[3]) begin
        e_cnt++;
        check("t6 E data after reset", data_o[3*DW +: DW], f);
      end
    end
    check("t6 E flit count", e_cnt, 1);
    check("t6 no stray S flit", stray_s, 1'b0);
  endtask

  initial begin
    yx_addr = {4'd2, 4'd2};
    do_reset();
    check("rst valid_o", valid_o, 5'b00000);
    check("rst credit_o", credit_o, 5'b00000);
    check("rst overflow_o", overflow_o, 5'b00000);
    check("rst data_o", data_o, '0);
    check("rst drop_cnt_o", drop_cnt_o, 0);
    check_counters_full("rst");

    test_local_to_e();
    do_reset();
    test_wormhole();
    do_reset();
    test_credit_stall();
    do_reset();
    test_overflow();
    do_reset();
    test_disabled_port();
    do_reset();
    test_reset_mid_packet();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mesh_router_param.md
Name: mesh_router_param

Overview:
- Parametrised 5-port (N,S,W,E,L) wormhole mesh router; single successor to the per-position edge/corner/centre router variants.
- PORT_EN selects which ports exist, so one module covers every mesh position.
- Per-input FIFO, YX routing, per-output round-robin arbitration with wormhole lock, credit-based flow control.
- Adds two behaviours the earlier routers lack: misroute dropping and overflow/drop status.

Parameters:
- DATA_W, 16, flit width in bits (min 2*COORD_W+2).
- COORD_W, 4, width of each of Y and X coordinates.
- BUF_DEPTH, 8, input FIFO depth in flits (power of 2, >=2); also the initial credit count per output.
- PORT_EN, 5'b11111, port enable mask in bit order {L,E,W,S,N} (bit0=N); bit4 (L) must be 1.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- yx_addr_router_i  input  2*COORD_W  this router's coordinates {y,x}; static after reset.
- data_i  input  5*DATA_W  input flits; port p occupies bits [p*DATA_W +: DATA_W], p: 0=N 1=S 2=W 3=E 4=L.
- valid_i  input  5  input flit valid, per port.
- credit_i  input  5  one-cycle credit return from the downstream buffer, per output.
- data_o  output  5*DATA_W  output flits, same packing as data_i.
- valid_o  output  5  output flit valid.
- credit_o  output  5  one-cycle credit returned upstream on each input FIFO pop.
- overflow_o  output  5  sticky per-input flag: a flit arrived while the FIFO was full.
- drop_cnt_o  output  8  saturating count of dropped packets (misrouted).

Behaviour:
Flit format:
- Bits [DATA_W-1:DATA_W-2] are the type: 01 head, 00 body, 10 tail, 11 single (head+tail).
- Head destination: y = [2*COORD_W-1:COORD_W], x = [COORD_W-1:0].

Reset (reset=0):
- All FIFOs empty.
- valid_o, credit_o, overflow_o, data_o, drop_cnt_o all 0.
- Every credit counter = BUF_DEPTH.
- Every output unlocked; every round-robin pointer gives N highest priority.
- Reset mid-packet discards all state; no partial flits are emitted after release.

Input FIFO:
- Written when valid_i[p]=1 and the FIFO is not full.
- If full, the flit is discarded and overflow_o[p] is set; it stays set until reset.
- Read and write in the same cycle are legal when full or empty. Pointers wrap modulo BUF_DEPTH.

Disabled port p (PORT_EN[p]=0):
- valid_i and credit_i are ignored.
- data_o, valid_o and credit_o for that port are tied to 0.

YX routing (computed on a head or single flit at the FIFO head; y grows southward, x grows eastward):
- dest.y<my.y -> N; dest.y>my.y -> S.
- Otherwise dest.x<my.x -> W; dest.x>my.x -> E.
- Otherwise -> L.

Drop rule:
- Applies when the target output is disabled or equals the input port (U-turn).
- The input enters DROP: it pops one flit per cycle, returning credit_o each pop, until a tail or single flit is popped.
- drop_cnt_o increments once per packet and saturates at 255.

Per-output arbitration:
- Requests come from inputs whose head flit routes to this output, while the output is unlocked and credit>0.
- Round-robin grant; the pointer moves to the port after the granted one.
- A grant locks the output to that input until its tail or single flit is forwarded.
- Body and tail flits of the locked input are forwarded whenever the FIFO is non-empty and credit>0.
- An input FIFO head is served by at most one output per cycle.

Forwarding:
- A granted flit pops from its FIFO and is registered into data_o/valid_o on the next edge.
- Zero-load latency: valid_i at cycle t -> valid_o at cycle t+2.
- credit_o[p] pulses at cycle t+2 as well (registered pop).
- If nothing is forwarded, valid_o=0 and data_o holds its last value.

Credit counter per output:
- Decremented on send, incremented on credit_i; both in the same cycle -> unchanged.
- Bounded to 0..BUF_DEPTH. An increment at BUF_DEPTH is ignored (assertion fires).
- No send occurs while the count is 0.

Test Plan:
- Local-to-E single flit: at router (2,2), a single flit to (2,5) on L -> E valid_o at t+2, data unchanged; L credit_o pulses once; E credit counter = 7.
- Wormhole contention: N and W both send 4-flit packets to L (dest = own address) in the same cycle -> N packet's 4 flits are contiguous on L output, then W's 4 flits; never interleaved.
- Credit stall: no credit_i on S; 10-flit packet from N routed S -> exactly 8 flits sent, stall, then one flit per credit_i pulse.
- Overflow: S output starved of credits, 12 back-to-back flits into N -> overflow_o[0]=1 after flit 9 is dropped; other flags 0.
- Disabled port: PORT_EN=5'b10111 (E off), head routed E -> packet fully consumed; drop_cnt_o 0->1; valid_o[3] stays 0; credit_o returned per flit.
- Reset mid-packet: assert reset during the flit-2 transfer -> all outputs 0 asynchronously; after release, counters = BUF_DEPTH and the new packet routes normally.
